// File: rtl/traffic_timer_pkg.sv
// Shared definitions for the intersection timer and the light FSM:
// interval select encodings, timer state encoding, light colour codes,
// and a helper that maps an interval select onto its tick count.
package traffic_pkg;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_SUM  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } timer_state_e;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'b00,
        LIGHT_GREEN  = 2'b01,
        LIGHT_YELLOW = 2'b10,
        LIGHT_OFF    = 2'b11
    } light_colour_e;

    // Tick count for an interval select; the sum is passed in pre-computed
    function automatic int interval_ticks(input logic [1:0] sel,
                                          input int t_base,
                                          input int t_ext,
                                          input int t_yel,
                                          input int t_sum);
        int ticks;
        case (sel)
            SEL_BASE: ticks = t_base;
            SEL_EXT:  ticks = t_ext;
            SEL_YEL:  ticks = t_yel;
            default:  ticks = t_sum;
        endcase
        return ticks;
    endfunction

endpackage

// File: rtl/traffic_timer_tick_prescaler.sv
// Free-running divide-by-DIV prescaler with synchronous clear.
// tick is high for one cycle when the count sits at DIV-1 while enabled.
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == W'(DIV - 1));

    // Next count: clear wins, otherwise count up and wrap on the tick
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + W'(1);
        end
    end

    // Prescaler count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_timer.sv
// Interval timer and walk-request latch for the intersection light FSM.
// A start loads an interval (in ticks) and a one-cycle expired pulse
// marks its end; walk presses are held until the FSM acknowledges them.
// Optional build macro RESTART_EN: a start during a running interval
// reloads it and abandons the old one without an expired pulse.
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int T_BASE  = 6,
    parameter int T_EXT   = 3,
    parameter int T_YEL   = 2,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_timer,
    input  logic [1:0]       interval_sel,
    input  logic             walk_req,
    input  logic             walk_ack,
    output logic             busy,
    output logic             expired,
    output logic [CNT_W-1:0] remaining,
    output logic             walk_pending
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int T_SUM = T_BASE + T_EXT;

    timer_state_e     state_q;
    logic             busy_q;
    logic             expired_q;
    logic [CNT_W-1:0] remaining_q;
    logic             walk_q;
    logic             walk_d;

    logic             tick;
    logic             accept;
    logic [CNT_W-1:0] load_val;

`ifdef RESTART_EN
    assign accept = start_timer;
`else
    assign accept = start_timer && (state_q != ST_RUN);
`endif

    // Interval length for the current select; a zero load becomes one tick
    always_comb begin
        load_val = CNT_W'(interval_ticks(interval_sel, T_BASE, T_EXT, T_YEL, T_SUM));
        if (load_val == '0) begin
            load_val = CNT_W'(1);
        end
    end

    tick_prescaler #(
        .DIV(DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear_i(accept),
        .en_i   (state_q == ST_RUN),
        .tick_o (tick)
    );

    // Timer FSM with registered busy/expired/remaining outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
            remaining_q <= '0;
        end else begin
            expired_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state_q     <= ST_RUN;
                        busy_q      <= 1'b1;
                        remaining_q <= load_val;
                    end else begin
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                        remaining_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        remaining_q <= load_val;
                    end else if (tick) begin
                        if (remaining_q == CNT_W'(1)) begin
                            state_q     <= ST_DONE;
                            busy_q      <= 1'b0;
                            expired_q   <= 1'b1;
                            remaining_q <= '0;
                        end else begin
                            remaining_q <= remaining_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    remaining_q <= '0;
                end
            endcase
        end
    end

    // Walk latch next value: a press wins over a simultaneous acknowledge
    always_comb begin
        walk_d = walk_q;
        if (walk_req) begin
            walk_d = 1'b1;
        end else if (walk_ack) begin
            walk_d = 1'b0;
        end
    end

    // Walk latch register, independent of the timer state
    always_ff @(posedge clk) begin
        if (rst) begin
            walk_q <= 1'b0;
        end else begin
            walk_q <= walk_d;
        end
    end

    assign busy         = busy_q;
    assign expired      = expired_q;
    assign remaining    = remaining_q;
    assign walk_pending = walk_q;

endmodule

// File: tb/tb_traffic_timer.sv
// Directed bench for traffic_timer at CLK_HZ=10, TICK_HZ=1 (ten cycles per tick).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_traffic_timer;

    logic       clk;
    logic       rst;
    logic       start_timer;
    logic [1:0] interval_sel;
    logic       walk_req;
    logic       walk_ack;
    logic       busy;
    logic       expired;
    logic [3:0] remaining;
    logic       walk_pending;

    int checks;
    int fails;

    traffic_timer #(
        .CLK_HZ (10),
        .TICK_HZ(1),
        .T_BASE (6),
        .T_EXT  (3),
        .T_YEL  (2),
        .CNT_W  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_timer (start_timer),
        .interval_sel(interval_sel),
        .walk_req    (walk_req),
        .walk_ack    (walk_ack),
        .busy        (busy),
        .expired     (expired),
        .remaining   (remaining),
        .walk_pending(walk_pending)
    );

    // 10ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare busy/expired/remaining against expected values
    task automatic check_timer(input string name, input int cyc,
                               input logic exp_busy, input logic exp_expired,
                               input logic [3:0] exp_rem);
        checks++;
        if (busy !== exp_busy || expired !== exp_expired || remaining !== exp_rem) begin
            fails++;
            $display("[TB] FAIL %s cycle %0d: got busy=%b expired=%b remaining=%0d, expected busy=%b expired=%b remaining=%0d",
                     name, cyc, busy, expired, remaining, exp_busy, exp_expired, exp_rem);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (expired !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_expired: got %b expected 0", expired);
        end
        checks++;
        if (remaining !== 4'd0) begin
            fails++;
            $display("[TB] FAIL reset_remaining: got %0d expected 0", remaining);
        end
        checks++;
        if (walk_pending !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_walk: got %b expected 0", walk_pending);
        end
    endtask

    // sel=00: six ticks of ten cycles; ends in the DONE cycle
    task automatic test_base_interval();
        logic [3:0] exp_rem;
        interval_sel = 2'b00;
        start_timer  = 1'b1;
        step();
        start_timer  = 1'b0;
        interval_sel = 2'b11;
        check_timer("base_start", 0, 1'b1, 1'b0, 4'd6);
        for (int i = 1; i <= 60; i++) begin
            step();
            exp_rem = (i < 60) ? 4'(6 - i / 10) : 4'd0;
            check_timer("base_run", i, (i < 60), (i == 60), exp_rem);
        end
    endtask

    // sel=10 started during the DONE cycle of the previous interval
    task automatic test_back_to_back();
        interval_sel = 2'b10;
        start_timer  = 1'b1;
        step();
        start_timer  = 1'b0;
        interval_sel = 2'b00;
        check_timer("b2b_start", 0, 1'b1, 1'b0, 4'd2);
        for (int i = 1; i <= 22; i++) begin
            step();
            check_timer("b2b_run", i, (i < 20), (i == 20),
                        (i < 10) ? 4'd2 : ((i < 20) ? 4'd1 : 4'd0));
        end
    endtask

    // sel=00 run with a sel=01 start sampled at cycle 25
    task automatic test_restart();
        int first_exp;
        int exp_at;
        int pulses;
`ifdef RESTART_EN
        exp_at = 55;
`else
        exp_at = 60;
`endif
        pulses    = 0;
        first_exp = -1;
        interval_sel = 2'b00;
        start_timer  = 1'b1;
        step();
        start_timer  = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            if (i == 25) begin
                interval_sel = 2'b01;
                start_timer  = 1'b1;
            end
            step();
            start_timer = 1'b0;
            if (i == 25) begin
                checks++;
`ifdef RESTART_EN
                if (remaining !== 4'd3) begin
                    fails++;
                    $display("[TB] FAIL restart_reload: got %0d expected 3", remaining);
                end
`else
                if (remaining !== 4'd4) begin
                    fails++;
                    $display("[TB] FAIL restart_ignored: got %0d expected 4", remaining);
                end
`endif
            end
            if (expired === 1'b1) begin
                pulses++;
                if (first_exp < 0) first_exp = i;
            end
        end
        checks++;
        if (pulses != 1 || first_exp != exp_at) begin
            fails++;
            $display("[TB] FAIL restart_expired: got %0d pulses first at %0d, expected 1 pulse at %0d",
                     pulses, first_exp, exp_at);
        end
    endtask

    // Reset at cycle 25 of a sel=11 run aborts it silently
    task automatic test_reset_mid_run();
        int pulses;
        pulses = 0;
        interval_sel = 2'b11;
        start_timer  = 1'b1;
        step();
        start_timer  = 1'b0;
        check_timer("sum_start", 0, 1'b1, 1'b0, 4'd9);
        for (int i = 1; i <= 24; i++) begin
            step();
            if (expired === 1'b1) pulses++;
        end
        check_timer("sum_before_rst", 24, 1'b1, 1'b0, 4'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_timer("sum_after_rst", 25, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 100; i++) begin
            step();
            if (expired === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            fails++;
            $display("[TB] FAIL reset_abort: got %0d busy/expired cycles expected 0", pulses);
        end
    endtask

    // Walk latch: set wins over ack, ack alone clears, level holds
    task automatic test_walk();
        walk_req = 1'b1;
        walk_ack = 1'b1;
        step();
        checks++;
        if (walk_pending !== 1'b1) begin
            fails++;
            $display("[TB] FAIL walk_set_wins: got %b expected 1", walk_pending);
        end
        walk_req = 1'b0;
        step();
        checks++;
        if (walk_pending !== 1'b0) begin
            fails++;
            $display("[TB] FAIL walk_ack_clears: got %b expected 0", walk_pending);
        end
        walk_ack = 1'b0;
        walk_req = 1'b1;
        step();
        walk_req = 1'b0;
        repeat (3) step();
        checks++;
        if (walk_pending !== 1'b1) begin
            fails++;
            $display("[TB] FAIL walk_hold: got %b expected 1", walk_pending);
        end
    endtask

    initial begin
        checks       = 0;
        fails        = 0;
        rst          = 1'b0;
        start_timer  = 1'b0;
        interval_sel = 2'b00;
        walk_req     = 1'b0;
        walk_ack     = 1'b0;
        #2;
        test_reset();
        test_base_interval();
        test_back_to_back();
        repeat (3) step();
        test_restart();
        repeat (3) step();
        test_reset_mid_run();
        test_walk();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
